// File: rtl/motor_cmd_executor_if.sv
// Instruction handshake between the sequencer (master) and the motor executor (slave).
// One 4-bit drive instruction moves per cycle where cmd_valid and cmd_ready are both high.
interface motor_cmd_executor_if;
   logic       cmd_valid;
   logic [3:0] cmd_data;
   logic       cmd_ready;

   modport master (output cmd_valid, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/motor_cmd_executor.sv
// Executes one drive instruction: PWM at a torque-dependent duty for STEP_CYCLES,
// then a DEAD_CYCLES coast with both PWMs low, then returns to IDLE.
module motor_cmd_executor #(
   parameter int STEP_CYCLES = 50_000_000,
   parameter int PWM_PERIOD  = 1000,
   parameter int DEAD_CYCLES = 1000
) (
   input  logic                       CLOCK50,
   input  logic                       rst_n,
   motor_cmd_executor_if.slave        cmd,
   input  logic                       abort,
   output logic                       pwm_l,
   output logic                       pwm_r,
   output logic                       dir_l,
   output logic                       dir_r,
   output logic                       busy,
   output logic                       step_done,
   output logic                       aborted,
   output logic [7:0]                 step_count
);

   localparam int SW = $clog2(STEP_CYCLES);
   localparam int PW = $clog2(PWM_PERIOD + 1);
   localparam int DW = $clog2(DEAD_CYCLES + 1);

   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
   localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);
   localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
   localparam logic [PW-1:0] DUTY_1    = PW'(PWM_PERIOD / 4);
   localparam logic [PW-1:0] DUTY_2    = PW'(2 * (PWM_PERIOD / 4));
   localparam logic [PW-1:0] DUTY_3    = PW'(3 * (PWM_PERIOD / 4));
   localparam logic [PW-1:0] DUTY_4    = PW'(PWM_PERIOD);

   typedef enum logic [1:0] {IDLE, RUN, COAST} state_t;

   state_t          state;
   logic [SW-1:0]   step_cnt;
   logic [PW-1:0]   pwm_cnt;
   logic [PW-1:0]   pwm_cnt_next;
   logic [PW-1:0]   duty;
   logic [PW-1:0]   accept_duty;
   logic [DW-1:0]   dead_cnt;
   logic            last_run;

   always_comb begin
      accept_duty = DUTY_1;
      case (cmd.cmd_data[3:2])
         2'd0:    accept_duty = DUTY_1;
         2'd1:    accept_duty = DUTY_2;
         2'd2:    accept_duty = DUTY_3;
         default: accept_duty = DUTY_4;
      endcase
   end

   assign pwm_cnt_next  = (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
   assign last_run      = (state == RUN) && (step_cnt == STEP_LAST);
   assign cmd.cmd_ready = (state == IDLE);
   assign busy          = (state != IDLE);
   // Gated by abort so a coinciding abort suppresses the completion pulse.
   assign step_done     = last_run && !abort;

   always_ff @(posedge CLOCK50 or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         step_cnt   <= '0;
         pwm_cnt    <= '0;
         dead_cnt   <= '0;
         duty       <= '0;
         pwm_l      <= 1'b0;
         pwm_r      <= 1'b0;
         dir_l      <= 1'b0;
         dir_r      <= 1'b0;
         aborted    <= 1'b0;
         step_count <= '0;
      end else begin
         aborted <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd.cmd_valid && !abort) begin
                  state    <= RUN;
                  step_cnt <= '0;
                  pwm_cnt  <= '0;
                  duty     <= accept_duty;
                  // pwm_cnt starts at 0 and duty is never 0, so the first RUN cycle is high.
                  pwm_l    <= 1'b1;
                  pwm_r    <= 1'b1;
                  case (cmd.cmd_data[1:0])
                     2'b00:   begin dir_l <= 1'b1; dir_r <= 1'b1; end
                     2'b01:   begin dir_l <= 1'b0; dir_r <= 1'b0; end
                     2'b10:   begin dir_l <= 1'b0; dir_r <= 1'b1; end
                     default: begin dir_l <= 1'b1; dir_r <= 1'b0; end
                  endcase
               end
            end
            RUN: begin
               if (abort) begin
                  state   <= IDLE;
                  pwm_l   <= 1'b0;
                  pwm_r   <= 1'b0;
                  dir_l   <= 1'b0;
                  dir_r   <= 1'b0;
                  aborted <= 1'b1;
               end else if (last_run) begin
                  state      <= COAST;
                  dead_cnt   <= '0;
                  pwm_l      <= 1'b0;
                  pwm_r      <= 1'b0;
                  step_count <= step_count + 8'd1;
               end else begin
                  step_cnt <= step_cnt + 1'b1;
                  pwm_cnt  <= pwm_cnt_next;
                  pwm_l    <= (pwm_cnt_next < duty);
                  pwm_r    <= (pwm_cnt_next < duty);
               end
            end
            COAST: begin
               if (abort || (dead_cnt == DEAD_LAST)) begin
                  state   <= IDLE;
                  dir_l   <= 1'b0;
                  dir_r   <= 1'b0;
                  aborted <= abort;
               end else begin
                  dead_cnt <= dead_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_motor_cmd_executor.sv
// Directed bench for motor_cmd_executor with STEP_CYCLES=20, PWM_PERIOD=8, DEAD_CYCLES=4.
module tb_motor_cmd_executor;
   localparam int STEP = 20;
   localparam int PER  = 8;
   localparam int DEAD = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       abort = 1'b0;
   logic       pwm_l, pwm_r, dir_l, dir_r, busy, step_done, aborted;
   logic [7:0] step_count;

   int checks    = 0;
   int errors    = 0;
   int exp_count = 0;
   int done_seen = 0;

   motor_cmd_executor_if cmd_if ();

   motor_cmd_executor #(
      .STEP_CYCLES(STEP),
      .PWM_PERIOD (PER),
      .DEAD_CYCLES(DEAD)
   ) dut (
      .CLOCK50   (clk),
      .rst_n     (rst_n),
      .cmd       (cmd_if.slave),
      .abort     (abort),
      .pwm_l     (pwm_l),
      .pwm_r     (pwm_r),
      .dir_l     (dir_l),
      .dir_r     (dir_r),
      .busy      (busy),
      .step_done (step_done),
      .aborted   (aborted),
      .step_count(step_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ready"}, cmd_if.cmd_ready, 1);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_pwm"},   {pwm_l, pwm_r}, 0);
      chk({tag, "_dir"},   {dir_l, dir_r}, 0);
      chk({tag, "_count"}, step_count, exp_count[7:0]);
   endtask

   // Runs one full step. With hold set, cmd_valid stays high carrying junk data,
   // and nd is presented during the last coast cycle for the next accept.
   task automatic do_step(input logic [3:0] d, input logic edl, input logic edr,
                          input int duty, input bit hold, input logic [3:0] nd);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_data  = d;
      chk("accept_ready", cmd_if.cmd_ready, 1);
      tick();
      if (!hold) cmd_if.cmd_valid = 1'b0;
      for (int k = 1; k <= STEP; k++) begin
         if (hold) cmd_if.cmd_data = 4'($urandom);
         #1;
         chk("run_ready", cmd_if.cmd_ready, 0);
         chk("run_busy",  busy, 1);
         chk("run_dir",   {dir_l, dir_r}, {edl, edr});
         chk("run_pwm",   {pwm_l, pwm_r}, (((k - 1) % PER) < duty) ? 2'b11 : 2'b00);
         chk("run_done",  step_done, (k == STEP) ? 1 : 0);
         chk("run_count", step_count, exp_count[7:0]);
         if (step_done === 1'b1) done_seen++;
         tick();
      end
      exp_count = (exp_count + 1) % 256;
      for (int c = 1; c <= DEAD; c++) begin
         if (hold) cmd_if.cmd_data = (c == DEAD) ? nd : 4'($urandom);
         #1;
         chk("coast_busy",  busy, 1);
         chk("coast_pwm",   {pwm_l, pwm_r}, 0);
         chk("coast_dir",   {dir_l, dir_r}, {edl, edr});
         chk("coast_done",  step_done, 0);
         chk("coast_count", step_count, exp_count[7:0]);
         tick();
      end
      chk_idle("post_step");
   endtask

   initial begin
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_data  = 4'b0000;

      // Reset state
      tick();
      tick();
      chk_idle("reset");
      chk("reset_done",    step_done, 0);
      chk("reset_aborted", aborted, 0);
      rst_n = 1'b1;
      tick();

      // 1: forward, torque 0 (2 high / 6 low)
      do_step(4'b0000, 1'b1, 1'b1, 2, 1'b0, 4'b0000);

      // 2: left torque 3 (constant high), right torque 1 (4 high / 4 low)
      do_step(4'b1110, 1'b0, 1'b1, 8, 1'b0, 4'b0000);
      do_step(4'b0111, 1'b1, 1'b0, 4, 1'b0, 4'b0000);

      // 3: valid held high with changing data; second accept in first IDLE cycle
      do_step(4'b0001, 1'b0, 1'b0, 2, 1'b1, 4'b0110);
      do_step(4'b0110, 1'b0, 1'b1, 4, 1'b0, 4'b0000);
      chk("two_steps_count", step_count, 8'd5);

      // 4a: abort on RUN cycle 10
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_data  = 4'b0111;
      tick();
      cmd_if.cmd_valid = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      abort = 1'b1;
      #1;
      chk("abort10_done", step_done, 0);
      tick();
      abort = 1'b0;
      chk_idle("abort10");
      chk("abort10_pulse", aborted, 1);
      chk("abort10_done2", step_done, 0);
      tick();
      chk("abort10_single", aborted, 0);

      // 4b: abort coinciding with the last RUN cycle
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_data  = 4'b0000;
      tick();
      cmd_if.cmd_valid = 1'b0;
      for (int i = 1; i < STEP; i++) tick();
      chk("abort20_pre_done", step_done, 1);
      abort = 1'b1;
      #1;
      chk("abort20_done", step_done, 0);
      tick();
      abort = 1'b0;
      chk_idle("abort20");
      chk("abort20_pulse", aborted, 1);
      tick();
      chk("abort20_single", aborted, 0);
      chk("abort20_count", step_count, 8'd5);

      // 4c: abort in IDLE refuses a simultaneous command and does not pulse
      abort            = 1'b1;
      cmd_if.cmd_valid = 1'b1;
      tick();
      abort            = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      chk_idle("abort_idle");
      chk("abort_idle_pulse", aborted, 0);

      // 5: asynchronous reset mid-RUN
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_data  = 4'b1100;
      tick();
      cmd_if.cmd_valid = 1'b0;
      for (int i = 1; i < 5; i++) tick();
      chk("pre_rst_pwm", {pwm_l, pwm_r}, 2'b11);
      chk("pre_rst_dir", {dir_l, dir_r}, 2'b11);
      #2;
      rst_n = 1'b0;
      #1;
      exp_count = 0;
      chk_idle("async_rst");
      tick();
      rst_n = 1'b1;
      tick();
      chk_idle("rst_release");
      do_step(4'b0100, 1'b1, 1'b1, 4, 1'b0, 4'b0000);

      // 6: 256 back-to-back steps, step_count wraps to 0
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_count = 0;
      done_seen = 0;
      tick();
      for (int i = 0; i < 256; i++)
         do_step(4'b0000, 1'b1, 1'b1, 2, (i != 255), 4'b0000);
      chk("wrap_done_seen", done_seen, 256);
      chk("wrap_count",     step_count, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/motor_cmd_executor.md
Name: motor_cmd_executor

Overview:
Consumer end of the instruction stream popped from the instruction FIFO by the top-level sequencer.
- Accepts one 4-bit drive instruction per valid/ready handshake: bits [1:0] direction, bits [3:2] torque level.
- Drives left/right motor PWM and direction pins for a fixed step time, then a dead-time coast.
- Reports completion so the sequencer can pop the next instruction.

Parameters:
STEP_CYCLES, 50_000_000, clock cycles one instruction is driven (1 s at 50 MHz); must be >= 2.
PWM_PERIOD, 1000, PWM period in clock cycles; must be a multiple of 4 and >= 4.
DEAD_CYCLES, 1000, coast cycles after each step with both PWMs low; must be >= 1.

Ports:
CLOCK50  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  instruction present on cmd_data
cmd_data  in  4  [1:0] direction, [3:2] torque level
cmd_ready  out  1  executor can accept an instruction
abort  in  1  synchronous stop; highest priority after rst_n
pwm_l  out  1  left motor PWM
pwm_r  out  1  right motor PWM
dir_l  out  1  left motor direction: 1 = forward, 0 = reverse
dir_r  out  1  right motor direction: 1 = forward, 0 = reverse
busy  out  1  high in RUN and COAST
step_done  out  1  one-cycle pulse on the last RUN cycle of a completed step
aborted  out  1  one-cycle pulse the cycle after abort is sampled in RUN or COAST
step_count  out  8  completed steps, wraps 255 -> 0

Behaviour:
Reset (rst_n low, asynchronous):
- State IDLE; all counters 0.
- pwm_l, pwm_r, dir_l, dir_r, step_done, aborted = 0; step_count = 0.
- busy = 0; cmd_ready = 1. Both are decoded from state.

States: IDLE, RUN, COAST.
- cmd_ready = (state == IDLE).
- busy = (state != IDLE).

IDLE:
- If cmd_valid && !abort at a rising edge: latch cmd_data, clear the step and PWM counters, go to RUN.
- The first RUN cycle is the cycle after acceptance (one-cycle latency).

Direction decode, registered at acceptance and held through RUN and COAST:
- 00 forward: dir_l = 1, dir_r = 1.
- 01 reverse: dir_l = 0, dir_r = 0.
- 10 left turn: dir_l = 0, dir_r = 1.
- 11 right turn: dir_l = 1, dir_r = 0.

Torque to duty:
- duty = (torque + 1) * (PWM_PERIOD / 4), giving 25/50/75/100 %.
- Compute at parameter width; no overflow possible.

RUN:
- pwm_cnt counts 0 .. PWM_PERIOD-1 and wraps.
- pwm_l = pwm_r = (pwm_cnt < duty), registered. Torque 3 gives a constant 1.
- step_cnt counts 0 .. STEP_CYCLES-1. RUN lasts exactly STEP_CYCLES cycles.
- On the cycle where step_cnt == STEP_CYCLES-1: step_done = 1, step_count increments (mod 256), next state COAST.

COAST:
- pwm_l = pwm_r = 0; dir outputs held.
- Lasts exactly DEAD_CYCLES cycles, then IDLE. In IDLE, dir outputs return to 0.

Input handling:
- cmd_valid outside IDLE is ignored: nothing latched, no effect on counters.
- cmd_data changes after acceptance do not affect the running step.

Abort:
- In RUN or COAST: the next edge goes to IDLE, pwm and dir go to 0, aborted pulses one cycle.
- No step_done pulse and no step_count increment for the aborted step.
- Abort and the final RUN cycle together: abort wins, no step_done.
- Abort in IDLE: no effect and no aborted pulse. A simultaneous cmd_valid is refused.

Mid-operation rst_n:
- All outputs clear immediately (asynchronous).
- Operation resumes in IDLE on the first edge after release.

Pulse outputs: step_done and aborted never assert in the same cycle and never for more than one cycle.

Test Plan:
All scenarios use STEP_CYCLES=20, PWM_PERIOD=8, DEAD_CYCLES=4.

1. Reset released, cmd_data=4'b0000, cmd_valid for 1 cycle -> cmd_ready drops next cycle; dir_l = dir_r = 1; PWM pattern 2 high / 6 low repeating for 20 cycles; step_done pulses on RUN cycle 20; 4 coast cycles with PWM low; cmd_ready=1; step_count=1.
2. Direction codes: cmd_data=4'b1110 (left, torque 3) -> dir_l=0, dir_r=1, pwm constant 1 for 20 cycles. Then 4'b0111 (right, torque 1) -> dir_l=1, dir_r=0, pwm 4 high / 4 low.
3. cmd_valid held high with changing cmd_data through RUN and COAST -> only the first value is executed; a second accept occurs on the first IDLE cycle; step_count=2 after both steps.
4. Abort on RUN cycle 10 -> next cycle state IDLE, pwm/dir = 0, aborted pulses once, no step_done, step_count unchanged. Abort coinciding with RUN cycle 20 -> same result.
5. rst_n asserted asynchronously mid-RUN (between edges) -> outputs 0 immediately; step_count=0 after release; a new command is accepted normally.
6. 256 back-to-back completed steps -> step_count wraps 255 -> 0; step_done seen exactly 256 times.
